// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the wait-state memory responder.
package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam int          WAIT_CNT_W = 4;
  localparam logic [31:0] RDDATA_RST = 32'h0;

  // Offset of a byte address from the window base; wraps on underflow.
  function automatic logic [31:0] byte_offset(input logic [31:0] addr, input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/data_mem_resp_sp_ram.sv
// Single-port synchronous RAM with write enable and a registered read port.
module sp_ram
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Output register only moves on an enabled read, so it holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_rdata <= DATA_W'(RDDATA_RST);
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// Memory-mapped word RAM responder: accepts one access, inserts WAIT_CYCLES
// wait states, then acknowledges for one cycle with an error flag.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oAccessable,
  output logic        oErr
);

  localparam bit                    NO_WAIT     = (WAIT_CYCLES == 0);
  localparam int                    WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD   = WAIT_LOAD_I[WAIT_CNT_W-1:0];
  localparam logic [32:0]           IDX_LIMIT   = 33'd1 << ADDR_W;

  state_t                r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_ack;
  logic                  r_err_out;
  logic                  r_wr;
  logic                  r_err;
  logic [ADDR_W-1:0]     r_idx;
  logic [31:0]           r_wdata;

  logic [31:0]       w_offset;
  logic              w_req;
  logic              w_err_in;
  logic              w_idle;
  logic              w_enter_ack;
  logic              w_acc_wr;
  logic              w_acc_err;
  logic [ADDR_W-1:0] w_acc_idx;
  logic [31:0]       w_acc_wdata;
  logic              w_ram_en;

  assign w_offset = byte_offset(iAddr, BASE_ADDR);
  assign w_req    = iRd | iWr;
  assign w_err_in = (iAddr[1:0] != 2'b00)
                  | ({3'b000, w_offset[31:2]} >= IDX_LIMIT)
                  | (iRd & iWr);
  assign w_idle   = (r_state == IDLE);

  // With no wait states the RAM is accessed on the accepting edge itself, so
  // the access fields come straight from the inputs while idle.
  assign w_acc_wr    = w_idle ? iWr : r_wr;
  assign w_acc_err   = w_idle ? w_err_in : r_err;
  assign w_acc_idx   = w_idle ? w_offset[ADDR_W+1:2] : r_idx;
  assign w_acc_wdata = w_idle ? iWrData : r_wdata;

  assign w_enter_ack = !iRst && ((NO_WAIT && w_idle && w_req)
                              || (r_state == WAIT && r_cnt == '0));
  assign w_ram_en    = w_enter_ack && !w_acc_err;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_err_out <= 1'b0;
    end else begin
      r_ack     <= w_enter_ack;
      r_err_out <= w_enter_ack && w_acc_err;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (NO_WAIT) begin
              r_state <= ACK;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Access capture needs no reset: it is only consumed after an acceptance.
  always_ff @(posedge iClk) begin
    if (w_idle && w_req) begin
      r_wr    <= iWr;
      r_err   <= w_err_in;
      r_idx   <= w_offset[ADDR_W+1:2];
      r_wdata <= iWrData;
    end
  end

  sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .i_clk   (iClk),
    .i_srst  (iRst),
    .i_en    (w_ram_en),
    .i_we    (w_acc_wr),
    .i_addr  (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (oRdData)
  );

  assign oAccessable = r_ack;
  assign oErr        = r_err_out;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: three instances cover default timing,
// zero wait states and a non-zero base address.
module tb_data_mem_resp;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst   [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];

  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   mon_en;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t mon_e;

  data_mem_resp #(.ADDR_W(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) u_dut_a (
    .iClk(clk), .iRst(rst[0]), .iRd(rd[0]), .iWr(wr[0]), .iAddr(addr[0]),
    .iWrData(wdata[0]), .oRdData(rdata[0]), .oAccessable(ack[0]), .oErr(err[0]));

  data_mem_resp #(.ADDR_W(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_dut_b (
    .iClk(clk), .iRst(rst[1]), .iRd(rd[1]), .iWr(wr[1]), .iAddr(addr[1]),
    .iWrData(wdata[1]), .oRdData(rdata[1]), .oAccessable(ack[1]), .oErr(err[1]));

  data_mem_resp #(.ADDR_W(8), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_1000)) u_dut_c (
    .iClk(clk), .iRst(rst[2]), .iRd(rd[2]), .iWr(wr[2]), .iAddr(addr[2]),
    .iWrData(wdata[2]), .oRdData(rdata[2]), .oAccessable(ack[2]), .oErr(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void q_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t q_pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every acknowledge, checks oErr idle low.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (ack[k] === 1'b1) begin
          if (q_size(k) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d unexpected ack: got ack at cycle %0d expected none", k, cyc);
          end else begin
            mon_e = q_pop(k);
            chk($sformatf("dut%0d %s ack cycle", k, mon_e.name), cyc, mon_e.cyc);
            chk($sformatf("dut%0d %s oErr", k, mon_e.name), {31'b0, err[k]}, {31'b0, mon_e.err});
            chk($sformatf("dut%0d %s oRdData", k, mon_e.name), rdata[k], mon_e.rd);
            $display("dut%0d %s ack at cycle %0d err=%0b rdata=%h", k, mon_e.name, cyc, err[k], rdata[k]);
          end
        end else if (ack[k] !== 1'b0 || err[k] !== 1'b0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut%0d idle outputs: got ack=%b err=%b expected ack=0 err=0", k, ack[k], err[k]);
        end
      end
    end
  end

  // Issues one access at a negedge while the DUT is idle; returns at the
  // negedge of the cycle after ACK so the next call is back-to-back.
  task automatic access(input int k, input string name, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit exp_err, input bit drop);
    exp_t e;
    int   n;
    bit   seen;
    e.name = name;
    e.cyc  = cyc + 1 + wait_of(k);
    e.rd   = exp_rd;
    e.err  = exp_err;
    q_push(k, e);
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (drop && n == 1) begin
        rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
      end
      if (ack[k] === 1'b1) seen = 1'b1;
    end
    rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d %s timeout: got no ack in 20 cycles expected ack", k, name);
    end
    @(negedge clk);
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      chk($sformatf("dut%0d reset oRdData", k), rdata[k], 32'h0);
      chk($sformatf("dut%0d reset oAccessable", k), {31'b0, ack[k]}, 32'h0);
      chk($sformatf("dut%0d reset oErr", k), {31'b0, err[k]}, 32'h0);
    end
    mon_en = 1'b1;

    // Default instance: two wait states, base 0.
    access(0, "wr 0x10",        0, 1, 32'h10,  32'hCAFE_F00D, 32'h0,         0, 0);
    access(0, "rd 0x10",        1, 0, 32'h10,  32'h0,         32'hCAFE_F00D, 0, 0);
    access(0, "wr 0x0",         0, 1, 32'h0,   32'h1111_1111, 32'hCAFE_F00D, 0, 0);
    access(0, "rd misaligned",  1, 0, 32'h402, 32'h0,         32'hCAFE_F00D, 1, 0);
    access(0, "wr out-of-range",0, 1, 32'h400, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 0);
    access(0, "rd 0x0",         1, 0, 32'h0,   32'h0,         32'h1111_1111, 0, 0);
    access(0, "rd+wr 0x10",     1, 1, 32'h10,  32'h0,         32'h1111_1111, 1, 0);
    access(0, "rd 0x10 again",  1, 0, 32'h10,  32'h0,         32'hCAFE_F00D, 0, 0);
    access(0, "wr last word",   0, 1, 32'h3FC, 32'h0BAD_CAFE, 32'hCAFE_F00D, 0, 0);
    access(0, "rd last word",   1, 0, 32'h3FC, 32'h0,         32'h0BAD_CAFE, 0, 0);
    access(0, "wr 0x20",        0, 1, 32'h20,  32'hAAAA_5555, 32'h0BAD_CAFE, 0, 0);

    // Reset one cycle into WAIT: the write must vanish with no acknowledge.
    wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h0000_1234;
    @(negedge clk);
    wr[0] = 1'b0; addr[0] = 32'h0; wdata[0] = 32'h0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("dut0 oRdData after mid-wait reset", rdata[0], 32'h0);
    $display("dut0 mid-wait reset issued, no ack observed window done at cycle %0d", cyc);

    access(0, "rd 0x20 after reset", 1, 0, 32'h20, 32'h0,  32'hAAAA_5555, 0, 0);
    access(0, "wr 0x8 dropped",      0, 1, 32'h8,  32'h55, 32'hAAAA_5555, 0, 1);
    access(0, "rd 0x8",              1, 0, 32'h8,  32'h0,  32'h0000_0055, 0, 0);

    // Zero wait states, back-to-back accesses two cycles apart.
    access(1, "wr 0x0", 0, 1, 32'h0, 32'h0000_0A0A, 32'h0,         0, 0);
    access(1, "wr 0x4", 0, 1, 32'h4, 32'h0000_0B0B, 32'h0,         0, 0);
    access(1, "rd 0x0", 1, 0, 32'h0, 32'h0,         32'h0000_0A0A, 0, 0);
    access(1, "rd 0x4", 1, 0, 32'h4, 32'h0,         32'h0000_0B0B, 0, 0);

    // Base address 0x1000, one wait state.
    access(2, "wr 0x1000",    0, 1, 32'h1000, 32'h1234_5678, 32'h0,         0, 0);
    access(2, "rd 0x0FFC",    1, 0, 32'h0FFC, 32'h0,         32'h0,         1, 0);
    access(2, "rd 0x1000",    1, 0, 32'h1000, 32'h0,         32'h1234_5678, 0, 0);
    access(2, "rd 0x0",       1, 0, 32'h0,    32'h0,         32'h1234_5678, 1, 0);
    access(2, "wr 0x13FC",    0, 1, 32'h13FC, 32'h0F0F_0F0F, 32'h1234_5678, 0, 0);
    access(2, "rd 0x13FC",    1, 0, 32'h13FC, 32'h0,         32'h0F0F_0F0F, 0, 0);
    access(2, "rd 0x1400",    1, 0, 32'h1400, 32'h0,         32'h0F0F_0F0F, 1, 0);

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d scoreboard drained", k), q_size(k), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
